// File: rtl/branch_if.sv
// Redirect/link bus between the decode stage and branch_ctrl.
// master: decode side, which drives the instruction fields and operands and receives the
//         redirect (npc/get_npc), busy and the link-register write.
// slave : branch_ctrl side.
// Signals:
//   opcode, fun3, rd, imm, opc      decoded instruction fields
//   rs1_val/rs1_ready, rs2_val/rs2_ready  operand values and their valid flags
//   npc, get_npc                    next fetch address and one-cycle redirect pulse
//   busy                            control transfer in flight
//   link_we, link_rd, link_data     link-register write
interface branch_if;
   logic [6:0]  opcode;
   logic [2:0]  fun3;
   logic [4:0]  rd;
   logic [31:0] imm;
   logic [31:0] opc;
   logic [31:0] rs1_val;
   logic        rs1_ready;
   logic [31:0] rs2_val;
   logic        rs2_ready;
   logic [31:0] npc;
   logic        get_npc;
   logic        busy;
   logic        link_we;
   logic [4:0]  link_rd;
   logic [31:0] link_data;

   modport master (
      output opcode, fun3, rd, imm, opc, rs1_val, rs1_ready, rs2_val, rs2_ready,
      input  npc, get_npc, busy, link_we, link_rd, link_data
   );

   modport slave (
      input  opcode, fun3, rd, imm, opc, rs1_val, rs1_ready, rs2_val, rs2_ready,
      output npc, get_npc, busy, link_we, link_rd, link_data
   );
endinterface

// File: rtl/branch_ctrl.sv
// Resolves BRANCH/JAL/JALR instructions from decode. Captures the instruction in IDLE, waits in
// WAIT until the required operands have been latched, then spends one cycle in DONE, where it
// presents the registered redirect (npc, get_npc) and, for jumps with rd != 0, the link write.
// Ports:
//   clk  single clock, posedge
//   rst  synchronous active-high reset
//   bus  branch_if.slave: instruction fields/operands in, redirect/busy/link outputs out
module branch_ctrl (
   input  logic    clk,
   input  logic    rst,
   branch_if.slave bus
);
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;
   typedef enum logic [1:0] {KindBranch, KindJal, KindJalr} kind_e;

   state_e      state_q, state_d;
   kind_e       kind_q, kind_d;
   logic [31:0] opc_q, opc_d, imm_q, imm_d;
   logic [2:0]  fun3_q, fun3_d;
   logic [4:0]  rd_q, rd_d;
   logic [31:0] rs1_q, rs1_d, rs2_q, rs2_d;
   logic        rs1_vld_q, rs1_vld_d, rs2_vld_q, rs2_vld_d;
   logic [31:0] npc_q, npc_d, link_data_q, link_data_d;
   logic [4:0]  link_rd_q, link_rd_d;
   logic        get_npc_q, get_npc_d, link_we_q, link_we_d, busy_q, busy_d;

   logic        is_cti, idle, have_rs1, have_rs2, ops_ok, taken, go_done;
   kind_e       dec_kind, cur_kind;
   logic [31:0] cur_opc, cur_imm, cur_rs1, cur_rs2, target;
   logic [2:0]  cur_fun3;
   logic [4:0]  cur_rd;

   always_comb begin
      dec_kind = KindBranch;
      is_cti   = 1'b1;
      case (bus.opcode)
         OP_BRANCH: dec_kind = KindBranch;
         OP_JAL:    dec_kind = KindJal;
         OP_JALR:   dec_kind = KindJalr;
         default:   is_cti   = 1'b0;
      endcase
   end

   // In IDLE the instruction is evaluated straight off the bus so an instruction whose operands
   // are already ready resolves at the capture edge; afterwards the captured copy is used.
   always_comb begin
      idle     = (state_q == StIdle);
      cur_kind = idle ? dec_kind : kind_q;
      cur_opc  = idle ? bus.opc : opc_q;
      cur_imm  = idle ? bus.imm : imm_q;
      cur_fun3 = idle ? bus.fun3 : fun3_q;
      cur_rd   = idle ? bus.rd : rd_q;
      // A latched operand wins over whatever is on the bus now.
      cur_rs1  = rs1_vld_q ? rs1_q : bus.rs1_val;
      cur_rs2  = rs2_vld_q ? rs2_q : bus.rs2_val;
      have_rs1 = rs1_vld_q | bus.rs1_ready;
      have_rs2 = rs2_vld_q | bus.rs2_ready;
      ops_ok   = ((cur_kind == KindJal) | have_rs1) & ((cur_kind != KindBranch) | have_rs2);

      taken = 1'b0;
      case (cur_fun3)
         3'b000:  taken = (cur_rs1 == cur_rs2);
         3'b001:  taken = (cur_rs1 != cur_rs2);
         3'b100:  taken = ($signed(cur_rs1) < $signed(cur_rs2));
         3'b101:  taken = ($signed(cur_rs1) >= $signed(cur_rs2));
         3'b110:  taken = (cur_rs1 < cur_rs2);
         3'b111:  taken = (cur_rs1 >= cur_rs2);
         default: taken = 1'b0;
      endcase

      case (cur_kind)
         KindJal:  target = cur_opc + cur_imm;
         KindJalr: target = (cur_rs1 + cur_imm) & 32'hFFFF_FFFE;
         default:  target = taken ? (cur_opc + cur_imm) : (cur_opc + 32'd4);
      endcase
   end

   always_comb begin
      state_d     = state_q;
      kind_d      = kind_q;
      opc_d       = opc_q;
      imm_d       = imm_q;
      fun3_d      = fun3_q;
      rd_d        = rd_q;
      rs1_d       = rs1_q;
      rs2_d       = rs2_q;
      rs1_vld_d   = rs1_vld_q;
      rs2_vld_d   = rs2_vld_q;
      npc_d       = npc_q;
      link_rd_d   = link_rd_q;
      link_data_d = link_data_q;
      get_npc_d   = 1'b0;
      link_we_d   = 1'b0;
      go_done     = 1'b0;

      case (state_q)
         StIdle: begin
            if (is_cti) begin
               kind_d  = dec_kind;
               opc_d   = bus.opc;
               imm_d   = bus.imm;
               fun3_d  = bus.fun3;
               rd_d    = bus.rd;
               go_done = ops_ok;
               state_d = ops_ok ? StDone : StWait;
            end
         end
         StWait: begin
            if (ops_ok) begin
               go_done = 1'b1;
               state_d = StDone;
            end
         end
         StDone: begin
            state_d   = StIdle;
            rs1_vld_d = 1'b0;
            rs2_vld_d = 1'b0;
         end
         default: state_d = StIdle;
      endcase

      // Operands latch on the first ready cycle, at capture or while waiting.
      if ((state_q == StWait) || (idle && is_cti)) begin
         if (!rs1_vld_q && bus.rs1_ready) begin
            rs1_d     = bus.rs1_val;
            rs1_vld_d = 1'b1;
         end
         if (!rs2_vld_q && bus.rs2_ready) begin
            rs2_d     = bus.rs2_val;
            rs2_vld_d = 1'b1;
         end
      end

      if (go_done) begin
         get_npc_d = 1'b1;
         npc_d     = target;
         if ((cur_kind != KindBranch) && (cur_rd != 5'd0)) begin
            link_we_d   = 1'b1;
            link_rd_d   = cur_rd;
            link_data_d = cur_opc + 32'd4;
         end
      end

      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         kind_q      <= KindBranch;
         opc_q       <= 32'd0;
         imm_q       <= 32'd0;
         fun3_q      <= 3'd0;
         rd_q        <= 5'd0;
         rs1_q       <= 32'd0;
         rs2_q       <= 32'd0;
         rs1_vld_q   <= 1'b0;
         rs2_vld_q   <= 1'b0;
         npc_q       <= 32'd0;
         link_rd_q   <= 5'd0;
         link_data_q <= 32'd0;
         get_npc_q   <= 1'b0;
         link_we_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         kind_q      <= kind_d;
         opc_q       <= opc_d;
         imm_q       <= imm_d;
         fun3_q      <= fun3_d;
         rd_q        <= rd_d;
         rs1_q       <= rs1_d;
         rs2_q       <= rs2_d;
         rs1_vld_q   <= rs1_vld_d;
         rs2_vld_q   <= rs2_vld_d;
         npc_q       <= npc_d;
         link_rd_q   <= link_rd_d;
         link_data_q <= link_data_d;
         get_npc_q   <= get_npc_d;
         link_we_q   <= link_we_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.npc       = npc_q;
   assign bus.get_npc   = get_npc_q;
   assign bus.busy      = busy_q;
   assign bus.link_we   = link_we_q;
   assign bus.link_rd   = link_rd_q;
   assign bus.link_data = link_data_q;
endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl. Expected redirects are pushed to a scoreboard queue when an
// instruction is issued and popped when the redirect is due.
module tb_branch_ctrl;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_NOP    = 7'b0010011;

   typedef struct packed {
      logic [31:0] npc;
      logic        lwe;
      logic [4:0]  lrd;
      logic [31:0] ldata;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;
   exp_t sb[$];

   branch_if bus ();

   branch_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic nop();
      bus.opcode    = OP_NOP;
      bus.fun3      = 3'd0;
      bus.rd        = 5'd0;
      bus.imm       = 32'd0;
      bus.opc       = 32'd0;
      bus.rs1_ready = 1'b0;
      bus.rs2_ready = 1'b0;
   endtask

   task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                        input logic [31:0] imm, input logic [31:0] opc,
                        input logic [31:0] r1, input logic r1rdy,
                        input logic [31:0] r2, input logic r2rdy);
      bus.opcode    = op;
      bus.fun3      = f3;
      bus.rd        = rd;
      bus.imm       = imm;
      bus.opc       = opc;
      bus.rs1_val   = r1;
      bus.rs1_ready = r1rdy;
      bus.rs2_val   = r2;
      bus.rs2_ready = r2rdy;
   endtask

   task automatic push(input logic [31:0] npc, input logic lwe, input logic [4:0] lrd,
                       input logic [31:0] ldata);
      exp_t e;
      e.npc   = npc;
      e.lwe   = lwe;
      e.lrd   = lrd;
      e.ldata = ldata;
      sb.push_back(e);
   endtask

   task automatic compare_out(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         tests++;
         fails++;
         $error("FAIL %s: observed empty scoreboard expected an entry", tag);
      end else begin
         e = sb.pop_front();
         check({tag, "_get_npc"}, {31'd0, bus.get_npc}, 32'd1);
         check({tag, "_npc"}, bus.npc, e.npc);
         check({tag, "_link_we"}, {31'd0, bus.link_we}, {31'd0, e.lwe});
         if (e.lwe) begin
            check({tag, "_link_rd"}, {27'd0, bus.link_rd}, {27'd0, e.lrd});
            check({tag, "_link_data"}, bus.link_data, e.ldata);
         end
      end
   endtask

   initial begin
      logic [2:0]  f3s[6];
      logic [31:0] exps[6];
      f3s  = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b001, 3'b000};
      exps = '{32'h50, 32'h44, 32'h44, 32'h50, 32'h50, 32'h44};

      nop();
      bus.rs1_val = 32'd0;
      bus.rs2_val = 32'd0;
      tick();
      tick();
      rst = 1'b0;
      check("rst_npc", bus.npc, 32'd0);
      check("rst_get_npc", {31'd0, bus.get_npc}, 32'd0);
      check("rst_busy", {31'd0, bus.busy}, 32'd0);
      check("rst_link_we", {31'd0, bus.link_we}, 32'd0);
      check("rst_link_rd", {27'd0, bus.link_rd}, 32'd0);
      check("rst_link_data", bus.link_data, 32'd0);

      // BEQ taken, latency 1
      issue(OP_BRANCH, 3'b000, 5'd7, 32'h20, 32'h100, 32'd5, 1'b1, 32'd5, 1'b1);
      push(32'h120, 1'b0, 5'd0, 32'd0);
      tick();
      nop();
      compare_out("beq");
      check("beq_busy_c1", {31'd0, bus.busy}, 32'd1);
      tick();
      check("beq_get_npc_c2", {31'd0, bus.get_npc}, 32'd0);
      check("beq_busy_c2", {31'd0, bus.busy}, 32'd0);
      check("beq_npc_hold", bus.npc, 32'h120);

      // Signed vs unsigned compares on -1 vs 1
      for (int i = 0; i < 6; i++) begin
         issue(OP_BRANCH, f3s[i], 5'd0, 32'h10, 32'h40, 32'hFFFF_FFFF, 1'b1, 32'd1, 1'b1);
         push(exps[i], 1'b0, 5'd0, 32'd0);
         tick();
         nop();
         compare_out($sformatf("br_f3_%0d", f3s[i]));
         tick();
      end

      // JALR clears the LSB and writes the link register
      issue(OP_JALR, 3'b000, 5'd1, 32'h2, 32'h200, 32'h1001, 1'b1, 32'd0, 1'b0);
      push(32'h1002, 1'b1, 5'd1, 32'h204);
      tick();
      nop();
      compare_out("jalr");
      tick();
      check("jalr_link_we_c2", {31'd0, bus.link_we}, 32'd0);
      check("jalr_link_data_hold", bus.link_data, 32'h204);

      // BNE with rs1 late; rs2 changes after it was latched, JAL in WAIT is ignored
      issue(OP_BRANCH, 3'b001, 5'd0, 32'h40, 32'h300, 32'd0, 1'b0, 32'd7, 1'b1);
      push(32'h340, 1'b0, 5'd0, 32'd0);
      tick();
      nop();
      check("dly_busy_c1", {31'd0, bus.busy}, 32'd1);
      check("dly_get_npc_c1", {31'd0, bus.get_npc}, 32'd0);
      tick();
      issue(OP_JAL, 3'b000, 5'd4, 32'h800, 32'h900, 32'd0, 1'b0, 32'd9, 1'b1);
      check("dly_busy_c2", {31'd0, bus.busy}, 32'd1);
      tick();
      nop();
      bus.rs1_val   = 32'd9;
      bus.rs1_ready = 1'b1;
      check("dly_busy_c3", {31'd0, bus.busy}, 32'd1);
      check("dly_get_npc_c3", {31'd0, bus.get_npc}, 32'd0);
      tick();
      nop();
      compare_out("dly");
      check("dly_busy_c4", {31'd0, bus.busy}, 32'd1);
      tick();
      check("dly_busy_c5", {31'd0, bus.busy}, 32'd0);
      check("dly_get_npc_c5", {31'd0, bus.get_npc}, 32'd0);

      // Reset while waiting for rs1 drops the redirect
      issue(OP_JALR, 3'b000, 5'd3, 32'h4, 32'h600, 32'd0, 1'b0, 32'd0, 1'b0);
      tick();
      nop();
      check("rstw_get_npc_c1", {31'd0, bus.get_npc}, 32'd0);
      tick();
      rst = 1'b1;
      check("rstw_get_npc_c2", {31'd0, bus.get_npc}, 32'd0);
      tick();
      rst = 1'b0;
      bus.rs1_val   = 32'h500;
      bus.rs1_ready = 1'b1;
      check("rstw_busy_c3", {31'd0, bus.busy}, 32'd0);
      check("rstw_get_npc_c3", {31'd0, bus.get_npc}, 32'd0);
      check("rstw_link_we_c3", {31'd0, bus.link_we}, 32'd0);
      check("rstw_npc_c3", bus.npc, 32'd0);
      check("rstw_link_data_c3", bus.link_data, 32'd0);
      check("rstw_link_rd_c3", {27'd0, bus.link_rd}, 32'd0);
      tick();
      nop();
      check("rstw_get_npc_c4", {31'd0, bus.get_npc}, 32'd0);
      check("rstw_link_we_c4", {31'd0, bus.link_we}, 32'd0);
      check("rstw_busy_c4", {31'd0, bus.busy}, 32'd0);

      // JAL wrap-around with rd=0, a JAL in DONE is ignored, then an illegal fun3 branch
      issue(OP_JAL, 3'b000, 5'd0, 32'h8, 32'hFFFF_FFFC, 32'd0, 1'b0, 32'd0, 1'b0);
      push(32'h4, 1'b0, 5'd0, 32'd0);
      tick();
      issue(OP_JAL, 3'b000, 5'd5, 32'h100, 32'h1000, 32'd0, 1'b0, 32'd0, 1'b0);
      compare_out("jal_wrap");
      tick();
      check("done_ign_get_npc", {31'd0, bus.get_npc}, 32'd0);
      check("done_ign_busy", {31'd0, bus.busy}, 32'd0);
      issue(OP_BRANCH, 3'b010, 5'd0, 32'h40, 32'h80, 32'd3, 1'b1, 32'd3, 1'b1);
      push(32'h84, 1'b0, 5'd0, 32'd0);
      tick();
      nop();
      compare_out("illegal_f3");
      tick();
      check("illegal_get_npc_c2", {31'd0, bus.get_npc}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
